// File: rtl/note_sequencer.sv
// note_sequencer: steps a {song, step} address through external note ROMs, synthesises
// one square wave per voice and mixes the voices into a single PWM bit for the amplifier.
module note_sequencer #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int NUM_VOICES  = 2,
    parameter int STEP_W      = 9,
    parameter int SEL_W       = 1,
    parameter int STEP_CYCLES = 8_388_608
) (
    input  logic                    clk,
    input  logic                    RESET,
    input  logic                    pause,
    input  logic                    loop,
    input  logic [SEL_W-1:0]        song_sel,
    output logic [SEL_W+STEP_W-1:0] rom_addr,
    input  logic [6*NUM_VOICES-1:0] rom_note,
    output logic [NUM_VOICES-1:0]   voice_sq,
    output logic                    audio_out,
    output logic                    shutdown_n,
    output logic                    gain_sel,
    output logic [STEP_W-1:0]       step,
    output logic                    step_tick,
    output logic                    done
);

    localparam int DIV_W   = 20;
    localparam int TIMER_W = $clog2(STEP_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(STEP_CYCLES - 1);
    localparam logic [STEP_W-1:0]  STEP_LAST  = '1;
    localparam logic [3:0]         PWM_LAST   = 4'(NUM_VOICES - 1);

    // Half-period for every 6-bit note code, flattened; code 0 (rest) maps to 0.
    function automatic logic [64*DIV_W-1:0] build_half_table();
        logic [64*DIV_W-1:0] tbl;
        int octave;
        int freq;
        int half;
        tbl = '0;
        for (int code = 1; code < 64; code++) begin
            octave = code / 12;
            if (octave > 5) octave = 5;
            case (code % 12)
                0:       freq = 110;
                1:       freq = 117;
                2:       freq = 123;
                3:       freq = 131;
                4:       freq = 139;
                5:       freq = 147;
                6:       freq = 156;
                7:       freq = 165;
                8:       freq = 175;
                9:       freq = 185;
                10:      freq = 196;
                default: freq = 208;
            endcase
            half = (CLK_HZ / (2 * freq)) >> octave;
            tbl[code*DIV_W +: DIV_W] = half[DIV_W-1:0];
        end
        return tbl;
    endfunction

    localparam logic [64*DIV_W-1:0] HALF_TABLE = build_half_table();

    logic [DIV_W-1:0]   half_rom [64];
    logic [SEL_W-1:0]   song_reg;
    logic [TIMER_W-1:0] timer;
    logic               silent;
    logic               song_change;
    logic               rest_all;
    logic [3:0]         mix;
    logic [3:0]         pwm_ctr;

    for (genvar c = 0; c < 64; c++) begin : g_half
        assign half_rom[c] = HALF_TABLE[c*DIV_W +: DIV_W];
    end

    assign song_change = (song_sel != song_reg);
    assign rest_all    = done | silent;
    assign rom_addr    = {song_reg, step};
    assign gain_sel    = 1'b1;

    // The step timer counts elapsed cycles upward, so it resets to 0 and still
    // expires STEP_CYCLES cycles after reset; a song change outranks expiry.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            song_reg  <= '0;
            step      <= '0;
            timer     <= '0;
            step_tick <= 1'b0;
            done      <= 1'b0;
            silent    <= 1'b0;
        end else begin
            step_tick <= 1'b0;
            if (song_change) begin
                song_reg <= song_sel;
                step     <= '0;
                timer    <= '0;
                done     <= 1'b0;
                silent   <= 1'b1;
            end else if (!pause) begin
                if (timer == TIMER_LAST) begin
                    timer     <= '0;
                    step_tick <= 1'b1;
                    silent    <= 1'b0;
                    if (step != STEP_LAST) begin
                        step <= step + 1'b1;
                    end else if (loop) begin
                        step <= '0;
                    end else begin
                        done <= 1'b1;
                    end
                end else begin
                    timer <= timer + 1'b1;
                end
            end
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        logic [5:0]       note_reg;
        logic [5:0]       note_next;
        logic [DIV_W-1:0] div_ctr;
        logic             sq;

        assign note_next   = rest_all ? 6'd0 : rom_note[6*v +: 6];
        assign voice_sq[v] = sq;

        // A note change restarts the wave from a known phase rather than mid-cycle.
        always_ff @(posedge clk or posedge RESET) begin
            if (RESET) begin
                note_reg <= '0;
                div_ctr  <= '0;
                sq       <= 1'b0;
            end else if (!pause) begin
                if (note_next != note_reg) begin
                    note_reg <= note_next;
                    div_ctr  <= half_rom[note_next];
                    sq       <= 1'b0;
                end else if (note_reg == 6'd0) begin
                    sq <= 1'b0;
                end else if (div_ctr == '0) begin
                    sq      <= ~sq;
                    div_ctr <= half_rom[note_reg];
                end else begin
                    div_ctr <= div_ctr - 1'b1;
                end
            end
        end
    end

    always_comb begin
        mix = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            mix = mix + 4'(voice_sq[i]);
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            pwm_ctr    <= '0;
            audio_out  <= 1'b0;
            shutdown_n <= 1'b0;
        end else begin
            shutdown_n <= ~pause & ~done;
            if (pause) begin
                audio_out <= 1'b0;
            end else begin
                audio_out <= (pwm_ctr < mix);
                pwm_ctr   <= (pwm_ctr == PWM_LAST) ? 4'd0 : pwm_ctr + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: random playback/pause/song stimulus checked every cycle against a
// behavioural model of the sequencer built from note rules and frequency arithmetic.
module tb_note_sequencer;

    localparam int CLK_HZ      = 1_000_000;
    localparam int NV          = 2;
    localparam int STEPS       = 8;
    localparam int STEP_CYCLES = 16;

    logic        clk = 1'b0;
    logic        RESET;
    logic        pause;
    logic        loop;
    logic        song_sel;
    logic [3:0]  rom_addr;
    logic [11:0] rom_note;
    logic [1:0]  voice_sq;
    logic        audio_out;
    logic        shutdown_n;
    logic        gain_sel;
    logic [2:0]  step;
    logic        step_tick;
    logic        done;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    logic [11:0] rom_flat [16];
    int freq_tab [12] = '{110, 117, 123, 131, 139, 147, 156, 165, 175, 185, 196, 208};

    note_sequencer #(
        .CLK_HZ(CLK_HZ), .NUM_VOICES(NV), .STEP_W(3), .SEL_W(1), .STEP_CYCLES(STEP_CYCLES)
    ) dut (
        .clk(clk), .RESET(RESET), .pause(pause), .loop(loop), .song_sel(song_sel),
        .rom_addr(rom_addr), .rom_note(rom_note), .voice_sq(voice_sq),
        .audio_out(audio_out), .shutdown_n(shutdown_n), .gain_sel(gain_sel),
        .step(step), .step_tick(step_tick), .done(done)
    );

    always #5 clk = ~clk;

    // External synchronous note ROM, one cycle of latency.
    always @(posedge clk) rom_note <= rom_flat[rom_addr];

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int halfPeriod(input int code);
        int oct;
        if (code == 0) return 0;
        oct = code / 12;
        if (oct > 5) oct = 5;
        return (CLK_HZ / (2 * freq_tab[code % 12])) >> oct;
    endfunction

    // Reference model state.
    int  m_song, m_step, m_elapsed, m_pwm;
    bit  m_tick, m_done, m_silent, m_audio, m_sdn;
    int  m_romq [NV];
    int  m_note [NV];
    int  m_left [NV];
    bit [NV-1:0] m_sq;
    int  lit, capt;
    bit  rest_now;
    logic [11:0] rom_word;

    initial begin
        forever begin
            @(posedge clk or posedge RESET);
            if (RESET) begin
                m_song = 0; m_step = 0; m_elapsed = 0; m_pwm = 0;
                m_tick = 0; m_done = 0; m_silent = 0; m_audio = 0; m_sdn = 0;
                m_sq = '0;
                rom_word = rom_flat[0];
                for (int v = 0; v < NV; v++) begin
                    m_note[v] = 0;
                    m_left[v] = 0;
                    m_romq[v] = int'(rom_word[6*v +: 6]);
                end
            end else begin
                rest_now = m_done || m_silent;
                lit = 0;
                for (int v = 0; v < NV; v++) lit += int'(m_sq[v]);
                m_sdn = !pause && !m_done;
                if (pause) begin
                    m_audio = 1'b0;
                end else begin
                    m_audio = (m_pwm < lit);
                    m_pwm   = (m_pwm + 1) % NV;
                    for (int v = 0; v < NV; v++) begin
                        capt = rest_now ? 0 : m_romq[v];
                        if (capt != m_note[v]) begin
                            m_note[v] = capt;
                            m_left[v] = halfPeriod(capt);
                            m_sq[v]   = 1'b0;
                        end else if (m_note[v] == 0) begin
                            m_sq[v] = 1'b0;
                        end else if (m_left[v] == 0) begin
                            m_sq[v]   = ~m_sq[v];
                            m_left[v] = halfPeriod(m_note[v]);
                        end else begin
                            m_left[v]--;
                        end
                    end
                end
                rom_word = rom_flat[m_song * STEPS + m_step];
                for (int v = 0; v < NV; v++) m_romq[v] = int'(rom_word[6*v +: 6]);
                m_tick = 1'b0;
                if (int'(song_sel) != m_song) begin
                    m_song = int'(song_sel); m_step = 0; m_elapsed = 0;
                    m_done = 1'b0; m_silent = 1'b1;
                end else if (!pause) begin
                    if (m_elapsed == STEP_CYCLES - 1) begin
                        m_elapsed = 0; m_tick = 1'b1; m_silent = 1'b0;
                        if (m_step < STEPS - 1) m_step++;
                        else if (loop) m_step = 0;
                        else m_done = 1'b1;
                    end else begin
                        m_elapsed++;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                checkOutput("step", int'(step), m_step);
                checkOutput("rom_addr", int'(rom_addr), m_song * STEPS + m_step);
                checkOutput("step_tick", int'(step_tick), int'(m_tick));
                checkOutput("done", int'(done), int'(m_done));
                checkOutput("voice_sq", int'(voice_sq), int'(m_sq));
                checkOutput("audio_out", int'(audio_out), int'(m_audio));
                checkOutput("shutdown_n", int'(shutdown_n), int'(m_sdn));
                checkOutput("gain_sel", int'(gain_sel), 1);
            end
        end
    end

    task automatic applyStimulus(input bit p, input bit l, input bit s, input int n);
        @(negedge clk);
        pause    = p;
        loop     = l;
        song_sel = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic randomPhases(input int count);
        bit p, l, s;
        for (int i = 0; i < count; i++) begin
            p = ($urandom_range(0, 4) == 0);
            l = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 7) == 0) ? ~song_sel : song_sel;
            applyStimulus(p, l, s, $urandom_range(20, 200));
        end
    endtask

    initial begin
        int base [NV];
        int n;
        logic [11:0] word;
        bit new_song;

        // Songs mostly hold a base note per voice so waves get to toggle across steps.
        for (int s = 0; s < 2; s++) begin
            for (int v = 0; v < NV; v++)
                base[v] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(48, 63));
            for (int st = 0; st < STEPS; st++) begin
                word = '0;
                for (int v = 0; v < NV; v++)
                    word[6*v +: 6] = 6'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : base[v]);
                rom_flat[s*STEPS + st] = word;
            end
        end

        RESET = 1'b1; pause = 1'b0; loop = 1'b1; song_sel = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_step", int'(step), 0);
        checkOutput("reset_rom_addr", int'(rom_addr), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_voice_sq", int'(voice_sq), 0);
        checkOutput("reset_audio", int'(audio_out), 0);
        checkOutput("reset_shutdown_n", int'(shutdown_n), 0);
        checkOutput("reset_gain_sel", int'(gain_sel), 1);
        RESET  = 1'b0;
        chk_en = 1'b1;

        n = 0;
        for (int k = 0; k < 64; k++) begin
            @(posedge clk); #1;
            n++;
            if (step_tick) break;
        end
        checkOutput("first_tick_cycle", n, STEP_CYCLES);
        checkOutput("first_tick_addr", int'(rom_addr), 1);

        applyStimulus(0, 1, 0, 200);
        applyStimulus(1, 1, 0, 100);
        applyStimulus(0, 1, 0, 300);
        randomPhases(15);

        applyStimulus(0, 0, song_sel, 0);
        for (int k = 0; k < 400 && !done; k++) @(negedge clk);
        checkOutput("done_reached", int'(done), 1);
        repeat (40) @(negedge clk);
        checkOutput("done_step_hold", int'(step), STEPS - 1);
        checkOutput("done_shutdown_n", int'(shutdown_n), 0);
        checkOutput("done_audio", int'(audio_out), 0);

        new_song = ~song_sel;
        applyStimulus(0, 0, new_song, 1);
        checkOutput("song_step", int'(step), 0);
        checkOutput("song_done", int'(done), 0);
        checkOutput("song_rom_addr", int'(rom_addr), int'(new_song) * STEPS);

        applyStimulus(0, 1, song_sel, 37);
        #3 RESET = 1'b1;
        #1;
        checkOutput("async_step", int'(step), 0);
        checkOutput("async_rom_addr", int'(rom_addr), 0);
        checkOutput("async_voice_sq", int'(voice_sq), 0);
        checkOutput("async_audio", int'(audio_out), 0);
        checkOutput("async_shutdown_n", int'(shutdown_n), 0);
        checkOutput("async_step_tick", int'(step_tick), 0);
        repeat (2) @(negedge clk);
        RESET = 1'b0;

        randomPhases(15);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
